// File: rtl/csd_w8_pkg.sv
// Shared constants for the W8^k pipelined complex multiplier: the CSD form of
// K = 362/512 ~= 1/sqrt(2), rounding constant, twiddle index codes and widths.
package csd_w8_pkg;

    localparam int K            = 362;
    localparam int NB_COEF_FRAC = 9;

    // K = 2^9 - 2^7 - 2^4 - 2^2 - 2^1
    localparam int CSD_SH_ADD  = 9;
    localparam int CSD_SH_SUB0 = 7;
    localparam int CSD_SH_SUB1 = 4;
    localparam int CSD_SH_SUB2 = 2;
    localparam int CSD_SH_SUB3 = 1;

    localparam int ROUND_CONST = 1 << (NB_COEF_FRAC - 1);

    localparam logic [2:0] W8_K0 = 3'd0;
    localparam logic [2:0] W8_K1 = 3'd1;
    localparam logic [2:0] W8_K2 = 3'd2;
    localparam logic [2:0] W8_K3 = 3'd3;
    localparam logic [2:0] W8_K4 = 3'd4;
    localparam logic [2:0] W8_K5 = 3'd5;
    localparam logic [2:0] W8_K6 = 3'd6;
    localparam logic [2:0] W8_K7 = 3'd7;

    localparam int NB_INPUT_DEF = 16;
    localparam int NB_SUM_DEF   = NB_INPUT_DEF + 1;
    localparam int NB_PROD_DEF  = NB_INPUT_DEF + 11;

    function automatic int nb_sum(input int nb_in);
        return nb_in + 1;
    endfunction

    function automatic int nb_prod(input int nb_in);
        return nb_in + 11;
    endfunction

    // Width at which rounded products and negations are carried.
    function automatic int nb_neg(input int nb_in);
        return nb_in + 2;
    endfunction

endpackage

// File: rtl/csd_w8_cmult_pipe_csd_k0707_reg.sv
// Registered multiply by K = 362 using only shifts and subtracts; the
// product keeps all bits (NB_S + 10), so no rounding or wrap happens here.
module csd_k0707_reg
    import csd_w8_pkg::*;
#(
    parameter int NB_S = NB_SUM_DEF,
    parameter int NB_P = NB_S + 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_ce,
    input  logic signed [NB_S-1:0] i_s,
    output logic signed [NB_P-1:0] o_p
);

    logic signed [NB_P-1:0] w_s_ext;
    logic signed [NB_P-1:0] w_p;
    logic signed [NB_P-1:0] r_p;

    assign w_s_ext = {{(NB_P-NB_S){i_s[NB_S-1]}}, i_s};

    assign w_p = (w_s_ext <<< CSD_SH_ADD)
               - (w_s_ext <<< CSD_SH_SUB0)
               - (w_s_ext <<< CSD_SH_SUB1)
               - (w_s_ext <<< CSD_SH_SUB2)
               - (w_s_ext <<< CSD_SH_SUB3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
        end else if (i_ce) begin
            r_p <= w_p;
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/csd_w8_cmult_pipe.sv
// Three-stage complex multiply by W8^k = exp(-j*pi*k/4), k chosen per sample:
// pre-sums, CSD products, then select/round/negate/saturate into the output.
module csd_w8_cmult_pipe #(
    parameter int NB_INPUT     = 16,
    parameter int NB_OUTPUT    = NB_INPUT + 1,
    parameter int NB_COEF_FRAC = csd_w8_pkg::NB_COEF_FRAC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_ce,
    input  logic                        i_valid,
    input  logic [2:0]                  i_k,
    input  logic signed [NB_INPUT-1:0]  i_re,
    input  logic signed [NB_INPUT-1:0]  i_im,
    output logic                        o_valid,
    output logic signed [NB_OUTPUT-1:0] o_re,
    output logic signed [NB_OUTPUT-1:0] o_im,
    output logic                        o_sat
);

    localparam int NS = csd_w8_pkg::nb_sum(NB_INPUT);
    localparam int NP = csd_w8_pkg::nb_prod(NB_INPUT);
    localparam int NW = csd_w8_pkg::nb_neg(NB_INPUT);
    localparam int NC = (NB_OUTPUT > NW) ? NB_OUTPUT : NW;

    localparam logic signed [NP-1:0] RND = NP'(csd_w8_pkg::ROUND_CONST);
    localparam logic signed [NC-1:0] SAT_MAX = {{(NC-NB_OUTPUT+1){1'b0}}, {(NB_OUTPUT-1){1'b1}}};
    localparam logic signed [NC-1:0] SAT_MIN = {{(NC-NB_OUTPUT+1){1'b1}}, {(NB_OUTPUT-1){1'b0}}};

    // Stage 1: trivial pair and exact pre-sums re+im, im-re.
    logic signed [NS-1:0]       w_re_s, w_im_s;
    logic                       r1_valid;
    logic [2:0]                 r1_k;
    logic signed [NB_INPUT-1:0] r1_re, r1_im;
    logic signed [NS-1:0]       r1_s0, r1_s1;

    assign w_re_s = {i_re[NB_INPUT-1], i_re};
    assign w_im_s = {i_im[NB_INPUT-1], i_im};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_k     <= '0;
            r1_re    <= '0;
            r1_im    <= '0;
            r1_s0    <= '0;
            r1_s1    <= '0;
        end else if (i_ce) begin
            r1_valid <= i_valid;
            r1_k     <= i_k;
            r1_re    <= i_re;
            r1_im    <= i_im;
            r1_s0    <= w_re_s + w_im_s;
            r1_s1    <= w_im_s - w_re_s;
        end
    end

    // Stage 2: K*s0, K*s1 registered in the sub-module; side data forwarded.
    logic signed [NP-1:0]       w_p0, w_p1;
    logic                       r2_valid;
    logic [2:0]                 r2_k;
    logic signed [NB_INPUT-1:0] r2_re, r2_im;

    csd_k0707_reg #(.NB_S(NS), .NB_P(NP)) u_mul_s0 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ce  (i_ce),
        .i_s   (r1_s0),
        .o_p   (w_p0)
    );

    csd_k0707_reg #(.NB_S(NS), .NB_P(NP)) u_mul_s1 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ce  (i_ce),
        .i_s   (r1_s1),
        .o_p   (w_p1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_k     <= '0;
            r2_re    <= '0;
            r2_im    <= '0;
        end else if (i_ce) begin
            r2_valid <= r1_valid;
            r2_k     <= r1_k;
            r2_re    <= r1_re;
            r2_im    <= r1_im;
        end
    end

    // Stage 3: round half toward +inf, then select/negate at NW bits.
    logic signed [NP-1:0] w_p0_sum, w_p1_sum;
    logic signed [NW-1:0] w_p, w_q, w_re_t, w_im_t;
    logic signed [NW-1:0] w_sel_re, w_sel_im;
    logic                 w_unused_frac;

    assign w_p0_sum      = w_p0 + RND;
    assign w_p1_sum      = w_p1 + RND;
    assign w_p           = w_p0_sum[NB_COEF_FRAC +: NW];
    assign w_q           = w_p1_sum[NB_COEF_FRAC +: NW];
    assign w_unused_frac = ^{w_p0_sum[NB_COEF_FRAC-1:0], w_p1_sum[NB_COEF_FRAC-1:0]};
    assign w_re_t        = {{2{r2_re[NB_INPUT-1]}}, r2_re};
    assign w_im_t        = {{2{r2_im[NB_INPUT-1]}}, r2_im};

    always_comb begin
        w_sel_re = '0;
        w_sel_im = '0;
        case (r2_k)
            csd_w8_pkg::W8_K0: begin w_sel_re =  w_re_t; w_sel_im =  w_im_t; end
            csd_w8_pkg::W8_K1: begin w_sel_re =  w_p;    w_sel_im =  w_q;    end
            csd_w8_pkg::W8_K2: begin w_sel_re =  w_im_t; w_sel_im = -w_re_t; end
            csd_w8_pkg::W8_K3: begin w_sel_re =  w_q;    w_sel_im = -w_p;    end
            csd_w8_pkg::W8_K4: begin w_sel_re = -w_re_t; w_sel_im = -w_im_t; end
            csd_w8_pkg::W8_K5: begin w_sel_re = -w_p;    w_sel_im = -w_q;    end
            csd_w8_pkg::W8_K6: begin w_sel_re = -w_im_t; w_sel_im =  w_re_t; end
            default:           begin w_sel_re = -w_q;    w_sel_im =  w_p;    end
        endcase
    end

    // Returns {clipped, value}; compared at NC bits so any NB_OUTPUT works.
    function automatic logic [NB_OUTPUT:0] f_sat(input logic signed [NW-1:0] v);
        logic signed [NC-1:0] v_c;
        v_c = NC'(v);
        if (v_c > SAT_MAX) return {1'b1, SAT_MAX[NB_OUTPUT-1:0]};
        if (v_c < SAT_MIN) return {1'b1, SAT_MIN[NB_OUTPUT-1:0]};
        return {1'b0, v_c[NB_OUTPUT-1:0]};
    endfunction

    logic [NB_OUTPUT:0]          w_sat_re, w_sat_im;
    logic                        r3_valid, r3_sat;
    logic signed [NB_OUTPUT-1:0] r3_re, r3_im;

    assign w_sat_re = f_sat(w_sel_re);
    assign w_sat_im = f_sat(w_sel_im);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_valid <= 1'b0;
            r3_re    <= '0;
            r3_im    <= '0;
            r3_sat   <= 1'b0;
        end else if (i_ce) begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_re  <= w_sat_re[NB_OUTPUT-1:0];
                r3_im  <= w_sat_im[NB_OUTPUT-1:0];
                r3_sat <= w_sat_re[NB_OUTPUT] | w_sat_im[NB_OUTPUT];
            end
        end
    end

    assign o_valid = r3_valid;
    assign o_re    = r3_re;
    assign o_im    = r3_im;
    assign o_sat   = r3_sat;

endmodule

// File: tb/tb_csd_w8_cmult_pipe.sv
// Directed bench for csd_w8_cmult_pipe: default-width instance (a) and a
// NB_OUTPUT=16 instance (b) share stimulus; expected values are hand-computed.
module tb_csd_w8_cmult_pipe;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_ce;
    logic               i_valid;
    logic [2:0]         i_k;
    logic signed [15:0] i_re, i_im;

    logic               a_o_valid, a_o_sat;
    logic signed [16:0] a_o_re, a_o_im;
    logic               b_o_valid, b_o_sat;
    logic signed [15:0] b_o_re, b_o_im;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q[$];
    bit          sb_on    = 1'b0;
    bit          hold_ref = 1'b0;
    bit          ce_at_edge;
    int          last_re, last_im;

    csd_w8_cmult_pipe #(.NB_INPUT(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_ce(i_ce), .i_valid(i_valid), .i_k(i_k),
        .i_re(i_re), .i_im(i_im), .o_valid(a_o_valid), .o_re(a_o_re),
        .o_im(a_o_im), .o_sat(a_o_sat)
    );

    csd_w8_cmult_pipe #(.NB_INPUT(16), .NB_OUTPUT(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_ce(i_ce), .i_valid(i_valid), .i_k(i_k),
        .i_re(i_re), .i_im(i_im), .o_valid(b_o_valid), .o_re(b_o_re),
        .o_im(b_o_im), .o_sat(b_o_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Scoreboard for the streaming test: pop on every enabled edge with a
    // valid output, and require held outputs on stalled edges.
    always @(posedge clk) begin
        ce_at_edge = i_ce;
        #1;
        if (sb_on) begin
            if (ce_at_edge) begin
                hold_ref = 1'b0;
                if (a_o_valid) begin
                    if (exp_q.size() == 0) begin
                        check("sb_extra", 1, 0);
                    end else begin
                        logic [63:0] e;
                        e = exp_q.pop_front();
                        last_re = e[63:32];
                        last_im = e[31:0];
                        check("sb_re", int'(a_o_re), last_re);
                        check("sb_im", int'(a_o_im), last_im);
                        hold_ref = 1'b1;
                    end
                end
            end else if (hold_ref) begin
                check("hold_valid", int'(a_o_valid), 1);
                check("hold_re", int'(a_o_re), last_re);
                check("hold_im", int'(a_o_im), last_im);
            end
        end
    end

    task automatic run_one(input string tag, input logic [2:0] k, input int re, input int im,
                           input int e_re, input int e_im, input int e_sat, input bit use_b);
        int lat;
        @(negedge clk);
        i_valid = 1'b1;
        i_k     = k;
        i_re    = 16'(re);
        i_im    = 16'(im);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 1;
        while (!(use_b ? b_o_valid : a_o_valid) && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        if (use_b) begin
            check({tag, "_re"},  int'(b_o_re),  e_re);
            check({tag, "_im"},  int'(b_o_im),  e_im);
            check({tag, "_sat"}, int'(b_o_sat), e_sat);
        end else begin
            check({tag, "_re"},  int'(a_o_re),  e_re);
            check({tag, "_im"},  int'(a_o_im),  e_im);
            check({tag, "_sat"}, int'(a_o_sat), e_sat);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int wait_cyc;
        rst_n   = 1'b0;
        i_ce    = 1'b1;
        i_valid = 1'b0;
        i_k     = '0;
        i_re    = '0;
        i_im    = '0;

        // Reset state
        #12;
        check("rst_a_valid", int'(a_o_valid), 0);
        check("rst_a_re",    int'(a_o_re),    0);
        check("rst_a_im",    int'(a_o_im),    0);
        check("rst_a_sat",   int'(a_o_sat),   0);
        check("rst_b_valid", int'(b_o_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single samples: CSD product, rounding tie, trivial rotations
        run_one("k1_1000",   3'd1,   1000, 0,    707,   -707, 0, 1'b0);
        run_one("k1_tie",    3'd1,    128, 0,     91,    -90, 0, 1'b0);
        run_one("k2_min",    3'd2, -32768, 5,      5,  32768, 0, 1'b0);
        run_one("k4_min",    3'd4, -32768, 5,  32768,     -5, 0, 1'b0);
        run_one("k3_mix",    3'd3,    300, -100, -283, -141, 0, 1'b0);

        // Narrow output: clipping
        run_one("b_k1_max",  3'd1,  32767, 32767, 32767,  0, 1, 1'b1);
        run_one("b_k4_min",  3'd4, -32768, 0,     32767,  0, 1, 1'b1);

        // Back-to-back stream k=0..7 with a 2-cycle stall carrying a junk sample
        exp_q.push_back({32'(1000),  32'(0)});
        exp_q.push_back({32'(707),   32'(-707)});
        exp_q.push_back({32'(0),     32'(-1000)});
        exp_q.push_back({32'(-707),  32'(-707)});
        exp_q.push_back({32'(-1000), 32'(0)});
        exp_q.push_back({32'(-707),  32'(707)});
        exp_q.push_back({32'(0),     32'(1000)});
        exp_q.push_back({32'(707),   32'(707)});
        sb_on = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                i_ce    = 1'b0;
                i_valid = 1'b1;
                i_k     = 3'd5;
                i_re    = 16'sd7;
                i_im    = 16'sd7;
                repeat (2) @(negedge clk);
                i_ce = 1'b1;
            end
            i_valid = 1'b1;
            i_k     = 3'(i);
            i_re    = 16'sd1000;
            i_im    = 16'sd0;
            @(negedge clk);
        end
        i_valid  = 1'b0;
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("sb_drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        sb_on = 1'b0;

        // Asynchronous reset with three samples in flight
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            i_k     = 3'd1;
            i_re    = 16'(100 * (i + 1));
            i_im    = 16'sd0;
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        i_valid = 1'b0;
        check("pre_rst_valid", int'(a_o_valid), 1);
        rst_n = 1'b0;
        #1;
        check("arst_a_valid", int'(a_o_valid), 0);
        check("arst_a_re",    int'(a_o_re),    0);
        check("arst_a_im",    int'(a_o_im),    0);
        check("arst_b_valid", int'(b_o_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_valid", int'(a_o_valid), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/csd_w8_cmult_pipe.md
Name: csd_w8_cmult_pipe

Overview:
Pipelined complex multiplier by any eighth root of unity W8^k = exp(-j*pi*k/4), k = 0..7, selected per sample. The 0.7071 factor is a CSD shift-add constant, so the block uses no multipliers. It supersedes the single fixed-coefficient, combinational, real-only CSD multiplier. Used between radix-2 butterfly stages of the parallel FFT: per-sample twiddle select, fixed latency, rounding to output width, saturation.

Parameters:
NB_INPUT, 16, width of each input component, signed two's complement
NB_OUTPUT, NB_INPUT+1, width of each output component; legal range NB_INPUT..NB_INPUT+4
NB_COEF_FRAC, 9, fractional bits of the CSD constant K = 362/512 = 0.70703125; fixed at 9 in this revision

Ports:
clk  in  1  clock; all registers rise-edge
rst_n  in  1  asynchronous active-low reset
i_ce  in  1  pipeline enable; 0 = every stage register holds
i_valid  in  1  input sample valid
i_k  in  3  twiddle index k, sampled together with the data
i_re  in  NB_INPUT  real part, signed
i_im  in  NB_INPUT  imaginary part, signed
o_valid  out  1  output valid
o_re  out  NB_OUTPUT  real result, signed; same fractional bit count as input
o_im  out  NB_OUTPUT  imaginary result, signed
o_sat  out  1  1 if either component clipped on this output sample

Behaviour:
- Reset (rst_n = 0, asynchronous): all valid bits, o_valid, o_re, o_im and o_sat go to 0 immediately. Data in flight is discarded. First output after release requires new i_valid.
- Latency: fixed 3 i_ce-qualified cycles for every k. A sample accepted at edge n (i_ce = 1) appears on the outputs after edge n+2 with i_ce = 1 at each edge, i.e. after three enabled edges in total.
- i_ce = 0: every stage register holds its value, including o_*. o_valid stays asserted if it was asserted. A sample presented while i_ce = 0 is not captured.
- The valid bit and k travel with the data. Registers whose stage is invalid may still update their data, but o_re/o_im/o_sat are updated only when the stage-3 valid is 1. Outputs hold their last value otherwise.
- Stage 1: register k and the trivial pair (re, im). Register pre-sums s0 = re+im and s1 = im-re, each NB_INPUT+1 bits. Sign-extend before the add; no wrap is allowed.
- Stage 2 (sub-module): compute K*s0 and K*s1 as (s<<9) - (s<<7) - (s<<4) - (s<<2) - (s<<1), full width NB_INPUT+11. Register the results. The trivial pair is forwarded alongside.
- Stage 3: select per k; "P = round(K*s0)" and "Q = round(K*s1)".
  - k0: (re, im)
  - k1: (P, Q)
  - k2: (im, -re)
  - k3: (Q, -P)
  - k4: (-re, -im)
  - k5: (-P, -Q)
  - k6: (-im, re)
  - k7: (-Q, P)
- Rounding: add 2^8, then arithmetic shift right by 9 (round half toward +inf). Rounding is applied before negation.
- Negation: done at NB_INPUT+2 bits so that -(-2^(NB_INPUT-1)) is exact.
- Saturation: clip each component to [-2^(NB_OUTPUT-1), 2^(NB_OUTPUT-1)-1]. o_sat = OR of the two clip events. With the default NB_OUTPUT, clipping never occurs.

Decomposition:
- Package csd_w8_pkg holds:
  - K = 362
  - NB_COEF_FRAC = 9
  - CSD shift set {9:+, 7:-, 4:-, 2:-, 1:-}
  - rounding constant 2^8
  - localparams W8_K0..W8_K7 for the index values
  - internal width localparams (NB_INPUT+1, NB_INPUT+11)
- One sub-module, csd_k0707_reg: a single registered CSD constant multiplier with enable, instantiated twice (for s0 and s1).

Test Plan:
1. NB_INPUT=16, k=1, re=1000, im=0 -> o_re=707, o_im=-707, o_sat=0, exactly 3 enabled edges after capture.
2. k=1, re=128, im=0 (rounding tie) -> o_re=91, o_im=-90.
3. k=2, re=-32768, im=5 -> o_re=5, o_im=32768. k=4, same input -> o_re=32768, o_im=-5. o_sat=0 in both cases.
4. NB_OUTPUT=16: k=1, re=im=32767 -> o_re=32767 (clipped from 46335), o_im=0, o_sat=1. k=4, re=-32768 -> o_re=32767, o_sat=1.
5. Back-to-back valid stream k=0..7 with re=1000, im=0. Toggle i_ce low for 2 cycles mid-stream -> outputs held, no sample lost or duplicated. Expected sequence:
   (1000,0), (707,-707), (0,-1000), (-707,-707), (-1000,0), (-707,707), (0,1000), (707,707).
6. Assert rst_n low asynchronously between clock edges with 3 samples in flight -> o_valid=0 immediately. After release with no new i_valid, o_valid stays 0.
